// File: rtl/util_fifo2avl_pkg.sv
// Shared types and sizing helpers for the FIFO-read to Avalon-ST aligner.
// The beat record layout is {data, enable, mode}; rec_w() gives its width.
package util_fifo2avl_pkg;

    typedef enum logic {
        MODE_FULL = 1'b0,
        MODE_PART = 1'b1
    } mode_e;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int rec_w(input int lanes, input int data_w);
        return lanes * data_w + lanes + 1;
    endfunction

endpackage

// File: rtl/util_fifo2avl_buf.sv
// Output buffer: DEPTH x WIDTH synchronous FIFO with show-ahead head entry.
// Pointers carry an extra wrap bit so full and empty are unambiguous.
module util_fifo2avl_buf
    import util_fifo2avl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_wr,
    input  logic [WIDTH-1:0]          i_wdata,
    input  logic                      i_rd,
    output logic [WIDTH-1:0]          o_rdata,
    output logic                      o_full,
    output logic                      o_empty,
    output logic [ptr_w(DEPTH):0]     o_count
);

    localparam int PW = ptr_w(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW:0]      r_wptr;
    logic [PW:0]      r_rptr;
    logic             w_do_wr;
    logic             w_do_rd;

    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
    assign o_count = r_wptr - r_rptr;
    assign o_rdata = r_mem[r_rptr[PW-1:0]];
    assign w_do_wr = i_wr & ~o_full;
    assign w_do_rd = i_rd & ~o_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_wr) begin
                r_mem[r_wptr[PW-1:0]] <= i_wdata;
                r_wptr                <= r_wptr + 1'b1;
            end
            if (w_do_rd) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/util_fifo2avl_align.sv
// FIFO-read to Avalon-ST aligner: per-mode delay lines, credit-throttled output buffer
// and partial-beat stretching. Define UTIL_FIFO2AVL_STAT_EN to add stall/back-pressure counters.
module util_fifo2avl_align
    import util_fifo2avl_pkg::*;
#(
    parameter int LANES     = 4,
    parameter int DATA_W    = 32,
    parameter int LAT_FULL  = 4,
    parameter int LAT_PART  = 6,
    parameter int STRETCH   = 2,
    parameter int BUF_DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      din_valid,
    input  logic [LANES-1:0]          din_enable,
    input  logic [LANES*DATA_W-1:0]   din_data,
    output logic                      din_ready,
    output logic                      dout_valid,
    output logic [LANES*DATA_W-1:0]   dout_data,
    output logic [LANES-1:0]          dout_enable,
    output logic                      dout_last,
    input  logic                      dout_ready
`ifdef UTIL_FIFO2AVL_STAT_EN
    ,
    output logic [15:0]               stat_stall,
    output logic [15:0]               stat_bp
`endif
);

    localparam int DW    = LANES * DATA_W;
    localparam int PW    = ptr_w(BUF_DEPTH);
    localparam int CW    = PW + 1;
    localparam int SCW   = $clog2(LAT_PART + 1);
    localparam int BCW   = (STRETCH > 1) ? $clog2(STRETCH) : 1;
    localparam int REC_W = rec_w(LANES, DATA_W);

    typedef struct packed {
        logic [DW-1:0]    data;
        logic [LANES-1:0] enable;
        mode_e            mode;
    } beat_t;

    logic             r_run;
    logic [CW-1:0]    r_inflight;
    logic [SCW-1:0]   r_pstall;
    logic [BCW-1:0]   r_beat_cnt;

    logic             w_accept;
    logic             w_in_full;
    logic             w_mode_stall;
    logic [CW:0]      w_occ;
    beat_t            w_in_beat;

    logic [LAT_FULL-1:0] w_f_vld;
    beat_t               w_f_dat [LAT_FULL];
    logic [LAT_PART-1:0] w_p_vld;
    beat_t               w_p_dat [LAT_PART];

    logic             w_wr;
    beat_t            w_wr_beat;
    logic [REC_W-1:0] w_rdata;
    beat_t            w_head;
    logic             w_buf_full;
    logic             w_buf_empty;
    logic [CW-1:0]    w_buf_count;
    logic             w_hs;
    logic             w_head_last;
    logic             w_pop;

    assign w_in_full    = &din_enable;
    assign w_mode_stall = w_in_full & (r_pstall != '0);
    assign w_occ        = {1'b0, r_inflight} + {1'b0, w_buf_count};
    assign din_ready    = r_run & (w_occ < (CW+1)'(BUF_DEPTH)) & ~w_mode_stall;
    assign w_accept     = din_valid & din_ready;

    always_comb begin
        w_in_beat        = '0;
        w_in_beat.data   = din_data;
        w_in_beat.enable = din_enable;
        w_in_beat.mode   = w_in_full ? MODE_FULL : MODE_PART;
    end

    // Stage 0 is the accept cycle itself; the buffer write is the last of LAT stages.
    assign w_f_vld[0] = w_accept & w_in_full;
    assign w_f_dat[0] = w_in_beat;
    assign w_p_vld[0] = w_accept & ~w_in_full;
    assign w_p_dat[0] = w_in_beat;

    for (genvar gi = 1; gi < LAT_FULL; gi++) begin : g_fst
        logic  r_vld;
        beat_t r_dat;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_vld <= 1'b0;
                r_dat <= '0;
            end else begin
                r_vld <= w_f_vld[gi-1];
                r_dat <= w_f_dat[gi-1];
            end
        end
        assign w_f_vld[gi] = r_vld;
        assign w_f_dat[gi] = r_dat;
    end

    for (genvar gi = 1; gi < LAT_PART; gi++) begin : g_pst
        logic  r_vld;
        beat_t r_dat;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_vld <= 1'b0;
                r_dat <= '0;
            end else begin
                r_vld <= w_p_vld[gi-1];
                r_dat <= w_p_dat[gi-1];
            end
        end
        assign w_p_vld[gi] = r_vld;
        assign w_p_dat[gi] = r_dat;
    end

    // Mode-change stall keeps the two lines from ever writing in the same cycle.
    assign w_wr      = w_f_vld[LAT_FULL-1] | w_p_vld[LAT_PART-1];
    assign w_wr_beat = w_p_vld[LAT_PART-1] ? w_p_dat[LAT_PART-1] : w_f_dat[LAT_FULL-1];

    util_fifo2avl_buf #(
        .WIDTH (REC_W),
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .i_wr    (w_wr & ~w_buf_full),
        .i_wdata (w_wr_beat),
        .i_rd    (w_pop),
        .o_rdata (w_rdata),
        .o_full  (w_buf_full),
        .o_empty (w_buf_empty),
        .o_count (w_buf_count)
    );

    assign w_head      = beat_t'(w_rdata);
    assign dout_valid  = ~w_buf_empty;
    assign dout_data   = w_head.data;
    assign dout_enable = w_head.enable;
    assign w_head_last = (w_head.mode == MODE_FULL) | (r_beat_cnt == BCW'(STRETCH - 1));
    assign dout_last   = dout_valid & w_head_last;
    assign w_hs        = dout_valid & dout_ready;
    assign w_pop       = w_hs & w_head_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_run      <= 1'b0;
            r_inflight <= '0;
            r_pstall   <= '0;
            r_beat_cnt <= '0;
        end else begin
            r_run      <= 1'b1;
            r_inflight <= r_inflight + CW'(w_accept) - CW'(w_wr);
            // Full beats are held off for LAT_PART cycles after the latest partial accept.
            if (w_accept & ~w_in_full) begin
                r_pstall <= SCW'(LAT_PART);
            end else if (r_pstall != '0) begin
                r_pstall <= r_pstall - 1'b1;
            end
            if (w_hs) begin
                r_beat_cnt <= w_head_last ? '0 : r_beat_cnt + 1'b1;
            end
        end
    end

`ifdef UTIL_FIFO2AVL_STAT_EN
    logic [15:0] r_stat_stall;
    logic [15:0] r_stat_bp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_stall <= '0;
            r_stat_bp    <= '0;
        end else begin
            if (din_valid & ~din_ready & (r_stat_stall != 16'hFFFF)) begin
                r_stat_stall <= r_stat_stall + 16'd1;
            end
            if (dout_valid & ~dout_ready & (r_stat_bp != 16'hFFFF)) begin
                r_stat_bp <= r_stat_bp + 16'd1;
            end
        end
    end

    assign stat_stall = r_stat_stall;
    assign stat_bp    = r_stat_bp;
`endif

endmodule
